fp_mul_issue: RTL and testbench

- Initiator/collector for the pipelined FP32 multiplier's valid/ready interface (fpnew-style: operands/tag in, result/status/tag out).
- Accepts operand pairs from an upstream stream and issues them to the FP unit with sequence tags.
- Collects results in order into a result FIFO and presents them downstream.
- Uses credit-based issue so no result is ever dropped, even when the FP unit's out_ready is honoured strictly.

---
 rtl/fp_mul_issue.sv | 119 +++++++++++
 tb/tb_fp_mul_issue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_issue.sv
// fp_mul_issue: credit-based issue/collect wrapper for a pipelined FP32 multiplier.
// Optional popped-status accumulator enabled by FP_MUL_ISSUE_STATUS_ACCUM_EN.
module fp_mul_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  output logic             fpu_in_valid_o,
  input  logic             fpu_in_ready_i,
  output logic [31:0]      fpu_op_a_o,
  output logic [31:0]      fpu_op_b_o,
  output logic [TAG_W-1:0] fpu_tag_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [31:0]      fpu_result_i,
  input  logic [4:0]       fpu_status_i,
  input  logic [TAG_W-1:0] fpu_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [4:0]       rsp_status_o,
  output logic             tag_err_o
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
  ,
  input  logic             status_clr_i,
  output logic [4:0]       status_acc_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  status;
  } rsp_t;

  rsp_t             mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, inflight;
  logic [TAG_W-1:0] issue_seq, expect_seq;
  logic [CW:0]      used;
  logic             credit_ok;
  logic             iss, res, res_ok, pop, bad_tag;

  assign used      = {1'b0, inflight} + {1'b0, count};
  assign credit_ok = rst_ni & (used < CAP);

  assign fpu_in_valid_o  = req_valid_i & credit_ok;
  assign req_ready_o     = fpu_in_ready_i & credit_ok;
  assign fpu_op_a_o      = req_a_i;
  assign fpu_op_b_o      = req_b_i;
  assign fpu_tag_o       = issue_seq;
  assign fpu_out_ready_o = rst_ni;

  assign iss     = fpu_in_valid_o & fpu_in_ready_i;
  assign res     = fpu_out_valid_i & fpu_out_ready_o;
  // a result with nothing outstanding is dropped so counters never underflow
  assign res_ok  = res & (inflight != '0);
  assign bad_tag = res & ((inflight == '0) | (fpu_tag_i != expect_seq));

  assign rsp_valid_o  = (count != '0);
  assign pop          = rsp_valid_o & rsp_ready_i;
  assign rsp_data_o   = mem[rptr].data;
  assign rsp_status_o = mem[rptr].status;

  always_ff @(posedge clk_i) begin
    if (res_ok) mem[wptr] <= {fpu_result_i, fpu_status_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      inflight   <= '0;
      issue_seq  <= '0;
      expect_seq <= '0;
      tag_err_o  <= 1'b0;
    end else begin
      if (iss) issue_seq <= issue_seq + TAG_W'(1);
      if (res_ok) begin
        expect_seq <= expect_seq + TAG_W'(1);
        wptr       <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (bad_tag) tag_err_o <= 1'b1;
      unique case ({iss, res_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      unique case ({res_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_acc_o <= '0;
    end else if (status_clr_i) begin
      status_acc_o <= pop ? rsp_status_o : 5'd0;
    end else if (pop) begin
      status_acc_o <= status_acc_o | rsp_status_o;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_issue.sv
// tb_fp_mul_issue: scoreboard bench with an in-order FP unit model.
// Covers FP_MUL_ISSUE_STATUS_ACCUM_EN when that macro is defined.
module tb_fp_mul_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 8;

  logic             clk = 0;
  logic             rst_ni;
  logic             req_valid_i, req_ready_o;
  logic [31:0]      req_a_i, req_b_i;
  logic             fpu_in_valid_o, fpu_in_ready_i;
  logic [31:0]      fpu_op_a_o, fpu_op_b_o;
  logic [TAG_W-1:0] fpu_tag_o;
  logic             fpu_out_valid_i, fpu_out_ready_o;
  logic [31:0]      fpu_result_i;
  logic [4:0]       fpu_status_i;
  logic [TAG_W-1:0] fpu_tag_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic [4:0]       rsp_status_o;
  logic             tag_err_o;
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
  logic             status_clr_i;
  logic [4:0]       status_acc_o;
  logic [4:0]       acc_model;
`endif

  fp_mul_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_op_a_o(fpu_op_a_o), .fpu_op_b_o(fpu_op_b_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .tag_err_o(tag_err_o)
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
    , .status_clr_i(status_clr_i), .status_acc_o(status_acc_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      a, b;
    logic [TAG_W-1:0] tag;
    int               due;
  } pend_t;
  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
  } exp_t;

  pend_t            pend[$];
  exp_t             exp_q[$];
  int               n_cmp = 0, n_bad = 0;
  int               cyc = 0, issued = 0, popped = 0;
  int               lat_min = 2, lat_max = 2;
  logic [TAG_W-1:0] tag_model = '0;
  bit               corrupt_en = 0;
  logic [TAG_W-1:0] corrupt_match = '0;

  // FP unit behaviour: a few known products, otherwise a fixed scramble
  function automatic logic [36:0] fpu_fn(logic [31:0] a, logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return {32'h40C0_0000, 5'h00};
    if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {32'h7FC0_0000, 5'h10};
    return {(a * 32'd3) ^ b, a[4:0] ^ b[9:5]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t  e;
    logic [36:0] r;
    if (rst_ni) begin
      if (fpu_in_valid_o && fpu_in_ready_i) begin
        chk("issue_tag", fpu_tag_o, tag_model);
        chk("credit_cap", (issued - popped) < DEPTH, 1);
        chk("req_ready_on_issue", req_ready_o, 1);
        pend.push_back('{fpu_op_a_o, fpu_op_b_o, fpu_tag_o,
                         cyc + int'($urandom_range(lat_max, lat_min))});
        r = fpu_fn(req_a_i, req_b_i);
        exp_q.push_back('{r[36:5], r[4:0]});
        issued++;
        tag_model++;
      end
      if (fpu_out_valid_i && fpu_out_ready_o && pend.size() > 0)
        void'(pend.pop_front());
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
      chk("status_acc", status_acc_o, acc_model);
      if (status_clr_i) acc_model = 5'd0;
`endif
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data_o, e.d);
          chk("rsp_status", rsp_status_o, e.s);
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
          acc_model = acc_model | e.s;
`endif
        end
        popped++;
      end
    end
  end

  task automatic fpu_model();
    logic [36:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && cyc >= pend[0].due) begin
        r = fpu_fn(pend[0].a, pend[0].b);
        fpu_out_valid_i = 1;
        fpu_result_i    = r[36:5];
        fpu_status_i    = r[4:0];
        fpu_tag_i = (corrupt_en && pend[0].tag == corrupt_match) ?
                    TAG_W'(5) : pend[0].tag;
      end else begin
        fpu_out_valid_i = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int start = issued;
    int k = 0;
    req_valid_i = 1;
    req_a_i = a;
    req_b_i = b;
    while (issued == start && k < 50) begin
      tick();
      k++;
    end
    req_valid_i = 0;
    if (k >= 50) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    rsp_ready_i = 1;
    while ((exp_q.size() != 0 || pend.size() != 0) && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) chk("drain_timeout", 0, 1);
    tick();
  endtask

  // async assert mid-cycle, release away from the clock edge
  task automatic do_reset();
    #2;
    rst_ni = 0;
    exp_q.delete();
    issued = 0;
    popped = 0;
    tag_model = '0;
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
    acc_model = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1;
    tick();
  endtask

  initial begin
    int base, k;
    rst_ni = 0;
    req_valid_i = 1;
    req_a_i = '0;
    req_b_i = '0;
    fpu_in_ready_i = 1;
    rsp_ready_i = 0;
    fpu_out_valid_i = 0;
    fpu_result_i = '0;
    fpu_status_i = '0;
    fpu_tag_i = '0;
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
    status_clr_i = 0;
    acc_model = '0;
`endif
    fork
      fpu_model();
    join_none

    repeat (3) tick();
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_fpu_in_valid", fpu_in_valid_o, 0);
    chk("rst_tag_err", tag_err_o, 0);
    req_valid_i = 0;
    @(negedge clk);
    rst_ni = 1;
    tick();

    // single op 2.0 * 3.0
    rsp_ready_i = 1;
    send(32'h4000_0000, 32'h4040_0000);
    drain();
    chk("single_popped", popped, 1);
    chk("single_tag_err", tag_err_o, 0);

    // backpressure: cap of DEPTH issues
    rsp_ready_i = 0;
    base = issued;
    req_valid_i = 1;
    req_a_i = $urandom;
    req_b_i = $urandom;
    repeat (20) tick();
    chk("bp_issue_count", issued - base, DEPTH);
    chk("bp_req_ready", req_ready_o, 0);
    chk("bp_rsp_valid", rsp_valid_o, 1);
    rsp_ready_i = 1;
    tick();
    rsp_ready_i = 0;
    chk("bp_req_ready_after_pop", req_ready_o, 1);
    repeat (10) tick();
    chk("bp_issue_after_pop", issued - base, DEPTH + 1);
    req_valid_i = 0;
    drain();

    // streaming with random latency and backpressure
    lat_min = 1;
    lat_max = 5;
    base = issued;
    k = 0;
    while (issued - base < 300 && k < 6000) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_a_i = $urandom;
      req_b_i = $urandom;
      fpu_in_ready_i = ($urandom_range(0, 4) != 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    if (k >= 6000) chk("stream_timeout", 0, 1);
    req_valid_i = 0;
    fpu_in_ready_i = 1;
    drain();
    chk("stream_no_loss", popped, issued);
    chk("stream_tag_err", tag_err_o, 0);

    // returned tag 5 where 3 is expected
    do_reset();
    lat_min = 2;
    lat_max = 2;
    corrupt_en = 1;
    corrupt_match = TAG_W'(3);
    for (int i = 0; i < 3; i++) send($urandom, $urandom);
    drain();
    chk("tagerr_before", tag_err_o, 0);
    send($urandom, $urandom);
    drain();
    chk("tagerr_set", tag_err_o, 1);
    chk("tagerr_delivered", popped, 4);
    repeat (5) tick();
    chk("tagerr_sticky", tag_err_o, 1);
    corrupt_en = 0;

    // reset with three operations in flight
    do_reset();
    chk("rst_clears_tag_err", tag_err_o, 0);
    lat_min = 8;
    lat_max = 8;
    for (int i = 0; i < 3; i++) send($urandom, $urandom);
    req_valid_i = 1;
    #2;
    rst_ni = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_req_ready", req_ready_o, 0);
    chk("midrst_fpu_in_valid", fpu_in_valid_o, 0);
    req_valid_i = 0;
    exp_q.delete();
    issued = 0;
    popped = 0;
    tag_model = '0;
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
    acc_model = '0;
`endif
    @(negedge clk);
    rst_ni = 1;
    k = 0;
    while (pend.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("stale_timeout", 0, 1);
    tick();
    chk("stale_tag_err", tag_err_o, 1);
    chk("stale_dropped", rsp_valid_o, 0);

    // inf * 0 gives NV
    do_reset();
    lat_min = 2;
    lat_max = 2;
    send(32'h7F80_0000, 32'h0000_0000);
    drain();
    chk("inf_zero_popped", popped, 1);
`ifdef FP_MUL_ISSUE_STATUS_ACCUM_EN
    chk("acc_nv", status_acc_o, 5'h10);
    status_clr_i = 1;
    tick();
    status_clr_i = 0;
    tick();
    chk("acc_cleared", status_acc_o, 5'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
